// File: rtl/db_pkg.sv
// Shared types, default widths and address helper for the double-buffered read sequencer.
package db_pkg;

  localparam int DB_DATA_W     = 16;
  localparam int DB_ADDR_W     = 16;
  localparam int DB_CNT_W      = 32;
  localparam int DB_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Moves a running address to the start of the next outer iteration by undoing the
  // inner-level offsets. Worked at 64 bits; callers truncate, so the result is modulo 2^ADDR_W.
  function automatic logic [63:0] addr_rebase(input logic [63:0] addr,
                                              input logic [63:0] stride,
                                              input logic [63:0] off_a,
                                              input logic [63:0] off_b);
    return addr + stride - off_a - off_b;
  endfunction

endpackage

// File: rtl/db_out_fifo.sv
// Synchronous output FIFO with a registered head word; push and pop may coincide at any fill level.
module db_out_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_nxt;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    rd_nxt   = rd_ptr_q + PTR_W'(1);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_nxt;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    // Head takes the pushed word when it becomes the only entry, else refills from storage on pop.
    if ((count_q == '0) || ((count_q == CW'(1)) && do_pop)) begin
      if (do_push) begin
        head_d = push_data;
      end
    end else if (do_pop) begin
      head_d = mem_q[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_data  = head_q;

endmodule

// File: rtl/db_read_sched.sv
// Read-side sequencer: walks a filled buffer with a 3-level affine pattern under FIFO credit.
// Optional perf counters are built when DB_READ_SCHED_PERF_EN is defined.
module db_read_sched
  import db_pkg::*;
#(
  parameter int DATA_W     = DB_DATA_W,
  parameter int ADDR_W     = DB_ADDR_W,
  parameter int CNT_W      = DB_CNT_W,
  parameter int FIFO_DEPTH = DB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_start_addr,
  input  logic [ADDR_W-1:0] cfg_stride_0,
  input  logic [ADDR_W-1:0] cfg_stride_1,
  input  logic [ADDR_W-1:0] cfg_stride_2,
  input  logic [CNT_W-1:0]  cfg_range_0,
  input  logic [CNT_W-1:0]  cfg_range_1,
  input  logic [CNT_W-1:0]  cfg_range_2,
  input  logic              wr_buf_done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              rd_buf_done,
  output logic              err
`ifdef DB_READ_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [15:0]       perf_bufs_read
`endif
);

  // state | meaning
  // IDLE  | waiting for a full buffer; loop counters reloaded on exit
  // ISSUE | one read per credited cycle until all three levels wrap

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [1:0]        full_bufs_q, full_bufs_d;
  logic [CNT_W-1:0]  i0_q, i0_d, i1_q, i1_d, i2_q, i2_d;
  logic [ADDR_W-1:0] off0_q, off0_d, off1_q, off1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FCW-1:0]    inflight_q, inflight_d;
  logic              mem_ren_q, mem_ren_d;
  logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
  logic              rd_buf_done_q, rd_buf_done_d;
  logic              err_q, err_d;

  logic [FCW-1:0]    fifo_count;
  logic [FCW:0]      used;
  logic [CNT_W-1:0]  last0, last1, last2;
  logic              wrap0, wrap1, wrap2;
  logic              credit_ok, issue, last_issue, valid_ok, fifo_pop;

  // A range of 0 behaves as 1, so its last index is 0 as well.
  assign last0 = (cfg_range_0 == '0) ? '0 : cfg_range_0 - CNT_W'(1);
  assign last1 = (cfg_range_1 == '0) ? '0 : cfg_range_1 - CNT_W'(1);
  assign last2 = (cfg_range_2 == '0) ? '0 : cfg_range_2 - CNT_W'(1);
  assign wrap0 = (i0_q == last0);
  assign wrap1 = (i1_q == last1);
  assign wrap2 = (i2_q == last2);

  // Reads committed to the output register count as in flight, so credit is never over-granted.
  assign used      = (FCW+1)'(inflight_q) + (FCW+1)'(fifo_count);
  assign credit_ok = (used < (FCW+1)'(FIFO_DEPTH));
  assign valid_ok  = mem_valid && (inflight_q != '0);
  assign fifo_pop  = out_valid && out_ready;

  always_comb begin
    state_d       = state_q;
    i0_d          = i0_q;
    i1_d          = i1_q;
    i2_d          = i2_q;
    off0_d        = off0_q;
    off1_d        = off1_q;
    addr_d        = addr_q;
    mem_ren_d     = 1'b0;
    mem_raddr_d   = mem_raddr_q;
    rd_buf_done_d = 1'b0;
    issue         = 1'b0;
    last_issue    = 1'b0;
    if (state_q == IDLE) begin
      if (full_bufs_q != 2'd0) begin
        state_d = ISSUE;
        i0_d    = '0;
        i1_d    = '0;
        i2_d    = '0;
        off0_d  = '0;
        off1_d  = '0;
        addr_d  = cfg_start_addr;
      end
    end else if (credit_ok) begin
      issue       = 1'b1;
      mem_ren_d   = 1'b1;
      mem_raddr_d = addr_q;
      if (!wrap0) begin
        i0_d   = i0_q + CNT_W'(1);
        off0_d = off0_q + cfg_stride_0;
        addr_d = addr_q + cfg_stride_0;
      end else begin
        i0_d   = '0;
        off0_d = '0;
        if (!wrap1) begin
          i1_d   = i1_q + CNT_W'(1);
          off1_d = off1_q + cfg_stride_1;
          addr_d = ADDR_W'(addr_rebase(64'(addr_q), 64'(cfg_stride_1), 64'(off0_q), 64'd0));
        end else begin
          i1_d   = '0;
          off1_d = '0;
          if (!wrap2) begin
            i2_d   = i2_q + CNT_W'(1);
            addr_d = ADDR_W'(addr_rebase(64'(addr_q), 64'(cfg_stride_2), 64'(off0_q),
                                         64'(off1_q)));
          end else begin
            last_issue    = 1'b1;
            rd_buf_done_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    full_bufs_d = full_bufs_q;
    err_d       = err_q;
    if (wr_buf_done && !last_issue) begin
      if (full_bufs_q == 2'd2) begin
        err_d = 1'b1;
      end else begin
        full_bufs_d = full_bufs_q + 2'd1;
      end
    end else if (!wr_buf_done && last_issue) begin
      full_bufs_d = full_bufs_q - 2'd1;
    end
    if (mem_valid && (inflight_q == '0)) begin
      err_d = 1'b1;
    end
    inflight_d = inflight_q + FCW'(issue) - FCW'(valid_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      full_bufs_q   <= '0;
      i0_q          <= '0;
      i1_q          <= '0;
      i2_q          <= '0;
      off0_q        <= '0;
      off1_q        <= '0;
      addr_q        <= '0;
      inflight_q    <= '0;
      mem_ren_q     <= 1'b0;
      mem_raddr_q   <= '0;
      rd_buf_done_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_bufs_q   <= full_bufs_d;
      i0_q          <= i0_d;
      i1_q          <= i1_d;
      i2_q          <= i2_d;
      off0_q        <= off0_d;
      off1_q        <= off1_d;
      addr_q        <= addr_d;
      inflight_q    <= inflight_d;
      mem_ren_q     <= mem_ren_d;
      mem_raddr_q   <= mem_raddr_d;
      rd_buf_done_q <= rd_buf_done_d;
      err_q         <= err_d;
    end
  end

  db_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (valid_ok),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign mem_ren     = mem_ren_q;
  assign mem_raddr   = mem_raddr_q;
  assign rd_buf_done = rd_buf_done_q;
  assign err         = err_q;

`ifdef DB_READ_SCHED_PERF_EN
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
  logic [15:0] perf_bufs_read_q, perf_bufs_read_d;

  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q;
    if ((state_q == ISSUE) && !credit_ok && (perf_stall_cycles_q != '1)) begin
      perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
    end
    perf_bufs_read_d = perf_bufs_read_q + {15'd0, rd_buf_done_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles_q <= '0;
      perf_bufs_read_q    <= '0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_bufs_read_q    <= perf_bufs_read_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_bufs_read    = perf_bufs_read_q;
`endif

endmodule

// File: tb/tb_db_read_sched.sv
// Directed bench for db_read_sched: vector table of address patterns plus multi-cycle corner sequences.
module tb_db_read_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_start_addr = '0, cfg_stride_0 = '0, cfg_stride_1 = '0, cfg_stride_2 = '0;
  logic [31:0] cfg_range_0 = '0, cfg_range_1 = '0, cfg_range_2 = '0;
  logic        wr_buf_done = 1'b0;
  logic        mem_ren;
  logic [15:0] mem_raddr;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        rd_buf_done;
  logic        err;

  db_read_sched dut (
    .clk(clk), .reset(reset),
    .cfg_start_addr(cfg_start_addr),
    .cfg_stride_0(cfg_stride_0), .cfg_stride_1(cfg_stride_1), .cfg_stride_2(cfg_stride_2),
    .cfg_range_0(cfg_range_0), .cfg_range_1(cfg_range_1), .cfg_range_2(cfg_range_2),
    .wr_buf_done(wr_buf_done),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rd_buf_done(rd_buf_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory core with one cycle of read latency.
  always @(posedge clk) begin
    #1;
    mem_valid = mem_ren;
    mem_rdata = mem_word(mem_raddr);
  end

  logic [15:0] ren_a[$];
  int          ren_c[$];
  logic [15:0] out_d[$];
  int          rd_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_ren) begin
        ren_a.push_back(mem_raddr);
        ren_c.push_back(cyc);
      end
      if (out_valid && out_ready) out_d.push_back(out_data);
      if (rd_buf_done) rd_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;
  int wr_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ren_a.delete();
    ren_c.delete();
    out_d.delete();
    rd_cnt = 0;
  endtask

  task automatic set_cfg(input logic [15:0] st, input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] s2, input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2);
    cfg_start_addr = st;
    cfg_stride_0 = s0; cfg_stride_1 = s1; cfg_stride_2 = s2;
    cfg_range_0 = r0; cfg_range_1 = r1; cfg_range_2 = r2;
  endtask

  task automatic pulse_wr();
    wr_buf_done = 1'b1;
    step();
    wr_buf_done = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic wait_done(input int n_rd, input int n_out, input int budget);
    int t = 0;
    while ((rd_cnt < n_rd || out_d.size() < n_out) && t < budget) begin
      step();
      t++;
    end
    chk("wait_timeout", 32'(t >= budget), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
    chk({tag, "_mem_raddr"}, 32'(mem_raddr), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_rd_buf_done"}, 32'(rd_buf_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  typedef struct {
    logic [15:0] start, s0, s1, s2;
    logic [31:0] r0, r1, r2;
    int          n;
    logic [15:0] a [9];
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{start:16'h0000, s0:16'd3, s1:16'd1, s2:16'd0, r0:32'd3, r1:32'd3, r2:32'd1, n:9,
              a:'{16'h0, 16'h3, 16'h6, 16'h1, 16'h4, 16'h7, 16'h2, 16'h5, 16'h8}};
    vt[1] = '{start:16'hFFFE, s0:16'd1, s1:16'd0, s2:16'd0, r0:32'd4, r1:32'd1, r2:32'd1, n:4,
              a:'{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
    vt[2] = '{start:16'h0010, s0:16'd7, s1:16'd7, s2:16'd7, r0:32'd0, r1:32'd0, r2:32'd0, n:1,
              a:'{16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
    vt[3] = '{start:16'h0100, s0:16'h1, s1:16'h10, s2:16'h100, r0:32'd2, r1:32'd2, r2:32'd2, n:8,
              a:'{16'h100, 16'h101, 16'h110, 16'h111, 16'h200, 16'h201, 16'h210, 16'h211, 16'h0}};
    vt[4] = '{start:16'h0005, s0:16'hFFFF, s1:16'h10, s2:16'h0, r0:32'd3, r1:32'd2, r2:32'd1, n:6,
              a:'{16'h5, 16'h4, 16'h3, 16'h15, 16'h14, 16'h13, 16'h0, 16'h0, 16'h0}};

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    chk_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Full 3x3x3 walk at one read per cycle
    set_cfg(16'h0, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3);
    clear_logs();
    pulse_wr();
    wait_done(1, 27, 400);
    repeat (4) step();
    chk("w27_reads", 32'(ren_a.size()), 32'd27);
    chk("w27_outs", 32'(out_d.size()), 32'd27);
    chk("w27_done_pulses", 32'(rd_cnt), 32'd1);
    if (ren_c.size() == 27) begin
      chk("w27_first_latency", 32'(ren_c[0] - wr_cyc), 32'd2);
      chk("w27_span", 32'(ren_c[26] - ren_c[0]), 32'd26);
    end
    for (int k = 0; k < 27 && k < ren_a.size(); k++) chk("w27_addr", 32'(ren_a[k]), 32'(k));
    for (int k = 0; k < 27 && k < out_d.size(); k++)
      chk("w27_data", 32'(out_d[k]), 32'(mem_word(16'(k))));

    // Vector table
    for (int v = 0; v < 5; v++) begin
      set_cfg(vt[v].start, vt[v].s0, vt[v].s1, vt[v].s2, vt[v].r0, vt[v].r1, vt[v].r2);
      clear_logs();
      step();
      pulse_wr();
      wait_done(1, vt[v].n, 200);
      repeat (4) step();
      chk($sformatf("v%0d_reads", v), 32'(ren_a.size()), 32'(vt[v].n));
      chk($sformatf("v%0d_outs", v), 32'(out_d.size()), 32'(vt[v].n));
      chk($sformatf("v%0d_done_pulses", v), 32'(rd_cnt), 32'd1);
      chk($sformatf("v%0d_err", v), 32'(err), 32'd0);
      if (ren_c.size() > 0) chk($sformatf("v%0d_latency", v), 32'(ren_c[0] - wr_cyc), 32'd2);
      for (int k = 0; k < vt[v].n && k < ren_a.size(); k++)
        chk($sformatf("v%0d_addr%0d", v, k), 32'(ren_a[k]), 32'(vt[v].a[k]));
      for (int k = 0; k < vt[v].n && k < out_d.size(); k++)
        chk($sformatf("v%0d_data%0d", v, k), 32'(out_d[k]), 32'(mem_word(vt[v].a[k])));
    end

    // Backpressure: credit caps issued reads at the FIFO depth
    out_ready = 1'b0;
    set_cfg(16'h0, 16'd1, 16'd3, 16'd0, 32'd3, 32'd3, 32'd1);
    clear_logs();
    step();
    pulse_wr();
    repeat (20) step();
    chk("bp_reads_capped", 32'(ren_a.size()), 32'd4);
    chk("bp_ren_low", 32'(mem_ren), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'(mem_word(16'h0)));
    out_ready = 1'b1;
    wait_done(1, 9, 200);
    repeat (4) step();
    chk("bp_reads", 32'(ren_a.size()), 32'd9);
    chk("bp_outs", 32'(out_d.size()), 32'd9);
    chk("bp_done_pulses", 32'(rd_cnt), 32'd1);
    for (int k = 0; k < 9 && k < ren_a.size(); k++) chk("bp_addr", 32'(ren_a[k]), 32'(k));
    for (int k = 0; k < 9 && k < out_d.size(); k++)
      chk("bp_data", 32'(out_d[k]), 32'(mem_word(16'(k))));

    // Two buffers queued, third pulse overflows
    set_cfg(16'h0040, 16'd1, 16'd0, 16'd0, 32'd4, 32'd1, 32'd1);
    clear_logs();
    step();
    wr_buf_done = 1'b1;
    step();
    wr_cyc = cyc;
    step();
    chk("ovf_err_before", 32'(err), 32'd0);
    step();
    wr_buf_done = 1'b0;
    chk("ovf_err_set", 32'(err), 32'd1);
    wait_done(2, 8, 200);
    repeat (10) step();
    chk("ovf_reads", 32'(ren_a.size()), 32'd8);
    chk("ovf_done_pulses", 32'(rd_cnt), 32'd2);
    chk("ovf_err_sticky", 32'(err), 32'd1);
    if (ren_c.size() >= 5) begin
      chk("ovf_latency", 32'(ren_c[0] - wr_cyc), 32'd2);
      chk("ovf_idle_gap", 32'(ren_c[4] - ren_c[3]), 32'd2);
    end
    for (int k = 0; k < 8 && k < ren_a.size(); k++)
      chk("ovf_addr", 32'(ren_a[k]), 32'(16'h0040 + 16'(k % 4)));

    // Reset during ISSUE
    set_cfg(16'h0020, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3);
    clear_logs();
    pulse_wr();
    repeat (5) step();
    chk("mid_ren_active", 32'(mem_ren), 32'd1);
    reset = 1'b1;
    step();
    chk_reset_outputs("mid_rst");
    reset = 1'b0;
    clear_logs();
    set_cfg(16'h0030, 16'd1, 16'd0, 16'd0, 32'd2, 32'd1, 32'd1);
    step();
    pulse_wr();
    wait_done(1, 2, 100);
    repeat (4) step();
    chk("post_rst_reads", 32'(ren_a.size()), 32'd2);
    chk("post_rst_done", 32'(rd_cnt), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);
    if (ren_a.size() == 2) begin
      chk("post_rst_latency", 32'(ren_c[0] - wr_cyc), 32'd2);
      chk("post_rst_addr0", 32'(ren_a[0]), 32'h30);
      chk("post_rst_addr1", 32'(ren_a[1]), 32'h31);
    end
    if (out_d.size() == 2) begin
      chk("post_rst_data0", 32'(out_d[0]), 32'(mem_word(16'h30)));
      chk("post_rst_data1", 32'(out_d[1]), 32'(mem_word(16'h31)));
    end else begin
      chk("post_rst_outs", 32'(out_d.size()), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

endmodule
